sdiv16: RTL and testbench



---
 rtl/sdiv16.sv | 169 ++++++++++++++++
 tb/tb_sdiv16.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sdiv16.sv
// ---------------------------------------------------------------------------
// sdiv16 : sequential signed WIDTH-by-WIDTH integer divider
//
// Produces a truncating (C-style) quotient and remainder. The magnitudes are
// divided by a restoring shift/subtract loop, one quotient bit per clock, and
// the signs are applied when the results are registered. The handshake
// (start/busy/irq/ack) matches the companion Booth multiplier.
//
// Optional build macro:
//   SDIV_EARLY_ZERO_EN - a zero divisor skips the iteration loop and
//                        finalizes on the first RUN edge (same results).
//
// Ports:
//   clk          global clock
//   reset        synchronous, active-high reset
//   start        rising edge launches a division (IDLE only)
//   ack          clears irq and busy while waiting for acknowledge
//   irq_enable   sampled at finalize; 1 = hold busy/irq until ack
//   data_a       signed dividend (latched at launch)
//   data_b       signed divisor  (latched at launch)
//   busy         division in progress or awaiting ack
//   irq          completion interrupt
//   quotient     signed quotient, held until the next finalize
//   remainder    signed remainder (sign of dividend), held likewise
//   div_by_zero  last completed division had a zero divisor
// ---------------------------------------------------------------------------
module sdiv16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ack,
  input  logic             irq_enable,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             irq,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  // The state encoding is exactly {busy, irq}, so both outputs come
  // straight from the state register.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b10,
    WAIT_ACK = 2'b11
  } state_t;

  state_t state, state_next;

  logic             start_prev;
  logic             start_posedge;
  logic             launch, step, finalize;
  logic             iter_done;
  logic [CW-1:0]    count;
  logic             sign_a, sign_b, zero;
  logic [WIDTH-1:0] a_latched;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem_shift;
  logic             rem_fits;

  assign busy = state[1];
  assign irq  = state[0];

  assign start_posedge = start & ~start_prev;

  // The partial remainder is always below the divisor (at most 0x8000), so
  // its top bit is clear and the shift never loses information.
  assign rem_shift = {rem[WIDTH-2:0], dividend[WIDTH-1]};
  assign rem_fits  = (rem_shift >= divisor);

`ifdef SDIV_EARLY_ZERO_EN
  assign iter_done = zero || (count == CW'(WIDTH));
`else
  assign iter_done = (count == CW'(WIDTH));
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic plus the one-cycle strobes that steer the datapath.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    step       = 1'b0;
    finalize   = 1'b0;
    case (state)
      IDLE: begin
        if (start_posedge) begin
          launch     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (iter_done) begin
          finalize   = 1'b1;
          state_next = irq_enable ? WAIT_ACK : IDLE;
        end else begin
          step = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring iteration per step, and sign
  // correction when the results are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_prev  <= 1'b0;
      count       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      zero        <= 1'b0;
      a_latched   <= '0;
      divisor     <= '0;
      dividend    <= '0;
      rem         <= '0;
      quo         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      start_prev <= start;
      if (launch) begin
        sign_a    <= data_a[WIDTH-1];
        sign_b    <= data_b[WIDTH-1];
        zero      <= (data_b == '0);
        a_latched <= data_a;
        dividend  <= data_a[WIDTH-1] ? -data_a : data_a;
        divisor   <= data_b[WIDTH-1] ? -data_b : data_b;
        rem       <= '0;
        quo       <= '0;
        count     <= '0;
      end
      if (step) begin
        rem      <= rem_fits ? (rem_shift - divisor) : rem_shift;
        quo      <= {quo[WIDTH-2:0], rem_fits};
        dividend <= {dividend[WIDTH-2:0], 1'b0};
        count    <= count + CW'(1);
      end
      if (finalize) begin
        if (zero) begin
          quotient    <= '1;
          remainder   <= a_latched;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= (sign_a ^ sign_b) ? -quo : quo;
          remainder   <= sign_a ? -rem : rem;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdiv16.sv
// ---------------------------------------------------------------------------
// tb_sdiv16 : self-checking bench for sdiv16
//
// The driver issues directed divisions and pushes the hand-computed results
// into a scoreboard queue; an independent monitor pops and compares whenever
// the DUT finalizes (irq rises, or busy falls without irq). Timing, reset and
// handshake behaviour are checked inline by the driver.
// ---------------------------------------------------------------------------
module tb_sdiv16;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ack;
  logic        irq_enable;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic        busy;
  logic        irq;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sb_q[$];
  logic [15:0] sb_r[$];
  logic        sb_dz[$];
  string       sb_name[$];

  sdiv16 #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ack         (ack),
    .irq_enable  (irq_enable),
    .data_a      (data_a),
    .data_b      (data_b),
    .busy        (busy),
    .irq         (irq),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one division from IDLE; returns on the negedge after launch.
  task automatic applyStimulus(input string name, input logic [15:0] a,
                               input logic [15:0] b, input logic irqen,
                               input logic [15:0] eq, input logic [15:0] er,
                               input logic edz, input bit push);
    data_a     = a;
    data_b     = b;
    irq_enable = irqen;
    start      = 1'b1;
    if (push) begin
      sb_q.push_back(eq);
      sb_r.push_back(er);
      sb_dz.push_back(edz);
      sb_name.push_back(name);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count negedges with busy high (bounded).
  task automatic measureBusy(output int cnt);
    cnt = 0;
    while (busy && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // Monitor: compare each finalized result against the scoreboard head.
  initial begin : monitor
    logic busy_q, irq_q;
    string nm;
    busy_q = 1'b0;
    irq_q  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && ((irq && !irq_q) || (!busy && busy_q && !irq_q))) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_result: got q=0x%0h r=0x%0h expected none",
                   quotient, remainder);
        end else begin
          nm = sb_name.pop_front();
          checkOutput({nm, "_quotient"}, {16'h0, quotient}, {16'h0, sb_q.pop_front()});
          checkOutput({nm, "_remainder"}, {16'h0, remainder}, {16'h0, sb_r.pop_front()});
          checkOutput({nm, "_div_by_zero"}, {31'h0, div_by_zero}, {31'h0, sb_dz.pop_front()});
        end
      end
      busy_q = busy;
      irq_q  = irq;
    end
  end

  // Driver: directed vectors with hand-computed expectations.
  initial begin : driver
    int cnt;
    int hi;
    reset      = 1'b1;
    start      = 1'b0;
    ack        = 1'b0;
    irq_enable = 1'b0;
    data_a     = 16'h0;
    data_b     = 16'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'h0, busy}, 0);
    checkOutput("reset_irq", {31'h0, irq}, 0);
    checkOutput("reset_quotient", {16'h0, quotient}, 0);
    checkOutput("reset_remainder", {16'h0, remainder}, 0);
    checkOutput("reset_div_by_zero", {31'h0, div_by_zero}, 0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus("d100_7", 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 1'b1);
    measureBusy(cnt);
    checkOutput("busy_cycles_100_7", cnt, 17);

    applyStimulus("dm100_7", 16'hFF9C, 16'd7, 1'b0, 16'hFFF2, 16'hFFFE, 1'b0, 1'b1);
    measureBusy(cnt);
    applyStimulus("d100_m7", 16'd100, 16'hFFF9, 1'b0, 16'hFFF2, 16'h0002, 1'b0, 1'b1);
    measureBusy(cnt);
    applyStimulus("dm100_m7", 16'hFF9C, 16'hFFF9, 1'b0, 16'h000E, 16'hFFFE, 1'b0, 1'b1);
    measureBusy(cnt);
    applyStimulus("dmin_m1", 16'h8000, 16'hFFFF, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1);
    measureBusy(cnt);
    applyStimulus("dmax_1", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 16'h0000, 1'b0, 1'b1);
    measureBusy(cnt);

    applyStimulus("d1234_0", 16'd1234, 16'd0, 1'b0, 16'hFFFF, 16'd1234, 1'b1, 1'b1);
    measureBusy(cnt);
`ifndef SDIV_EARLY_ZERO_EN
    checkOutput("busy_cycles_div0", cnt, 17);
`endif
    applyStimulus("d9_3", 16'd9, 16'd3, 1'b0, 16'd3, 16'd0, 1'b0, 1'b1);
    measureBusy(cnt);

    // Interrupt-style completion with an ignored start during WAIT_ACK.
    applyStimulus("d50_5_irq", 16'd50, 16'd5, 1'b1, 16'd10, 16'd0, 1'b0, 1'b1);
    cnt = 0;
    while (!irq && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("irq_latency", cnt, 17);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy && irq) hi++;
      if (i == 3) begin
        data_a = 16'd7;
        data_b = 16'd7;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("irq_hold_cycles", hi, 10);
    checkOutput("q_held_in_wait", {16'h0, quotient}, 16'd10);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkOutput("busy_after_ack", {31'h0, busy}, 0);
    checkOutput("irq_after_ack", {31'h0, irq}, 0);
    checkOutput("q_held_after_ack", {16'h0, quotient}, 16'd10);
    repeat (2) @(negedge clk);
    checkOutput("no_spurious_launch", {31'h0, busy}, 0);

    // Abandon an operation with reset sampled at E8.
    applyStimulus("d1000_3_abandon", 16'd1000, 16'd3, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_busy", {31'h0, busy}, 0);
    checkOutput("midreset_irq", {31'h0, irq}, 0);
    checkOutput("midreset_quotient", {16'h0, quotient}, 0);
    checkOutput("midreset_remainder", {16'h0, remainder}, 0);
    checkOutput("midreset_div_by_zero", {31'h0, div_by_zero}, 0);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus("d1000_3", 16'd1000, 16'd3, 1'b0, 16'd333, 16'd1, 1'b0, 1'b1);
    measureBusy(cnt);
    checkOutput("busy_cycles_1000_3", cnt, 17);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
